// File: rtl/pipe_pkg.sv
// Shared constants and status-FSM encoding for the fetch/decode pipeline slice.
package pipe_pkg;

   localparam int unsigned PC_W         = 32;
   localparam int unsigned CTRL_W_DEF   = 10;
   localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_ERR   = 2'd2
   } stat_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with async active-low clear; ENABLE=0 ties it off at zero.
module sat_counter #(
   parameter int unsigned WIDTH  = 16,
   parameter bit          ENABLE = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc_en,
   output logic [WIDTH-1:0] cnt
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (ENABLE && inc_en && (cnt_q != {WIDTH{1'b1}})) begin
         cnt_d = cnt_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/fetch_decode_pipe.sv
// PC, IF/ID and ID/EX registers driven by hazard-unit controls, with stall/flush
// statistics and a sticky excessive-stall status FSM.
module fetch_decode_pipe
   import pipe_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = RESET_PC_DEF,
   parameter int unsigned CTRL_W      = CTRL_W_DEF,
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned STALL_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              PC_wr_en,
   input  logic              IF_ID_wr_en,
   input  logic              nop_flag,
   input  logic              flush_flag,
   input  logic [PC_W-1:0]   pc_next,
   input  logic [31:0]       if_instr,
   input  logic [CTRL_W-1:0] id_ctrl,
   output logic [PC_W-1:0]   pc,
   output logic [31:0]       IF_ID_instr,
   output logic [PC_W-1:0]   IF_ID_pc4,
   output logic              IF_ID_valid,
   output logic [CTRL_W-1:0] ID_EX_ctrl,
   output logic              ID_EX_valid,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt,
   output logic              stall_err
);

   localparam int unsigned CONS_W = ($clog2(STALL_LIMIT + 1) < 1) ? 1 : $clog2(STALL_LIMIT + 1);

   logic [PC_W-1:0]   pc_q, pc_d;
   logic [31:0]       ifid_instr_q, ifid_instr_d;
   logic [PC_W-1:0]   ifid_pc4_q, ifid_pc4_d;
   logic              ifid_valid_q, ifid_valid_d;
   logic [CTRL_W-1:0] idex_ctrl_q, idex_ctrl_d;
   logic              idex_valid_q, idex_valid_d;
   logic [CONS_W-1:0] consec_q, consec_d;
   stat_state_e       state_q, state_d;
   logic              err_q, err_d;
   logic              flush_take_c;

   // A flush only lands when IF/ID is allowed to load.
   assign flush_take_c = IF_ID_wr_en && flush_flag;

   always_comb begin
      pc_d         = pc_q;
      ifid_instr_d = ifid_instr_q;
      ifid_pc4_d   = ifid_pc4_q;
      ifid_valid_d = ifid_valid_q;
      idex_ctrl_d  = id_ctrl;
      idex_valid_d = ifid_valid_q;

      if (PC_wr_en) begin
         pc_d = pc_next;
      end

      if (flush_take_c) begin
         ifid_instr_d = NOP_INSTR;
         ifid_pc4_d   = '0;
         ifid_valid_d = 1'b0;
      end else if (IF_ID_wr_en) begin
         ifid_instr_d = if_instr;
         ifid_pc4_d   = pc_q + PC_W'(4);
         ifid_valid_d = 1'b1;
      end

      if (nop_flag) begin
         idex_ctrl_d  = '0;
         idex_valid_d = 1'b0;
      end
   end

   // Status FSM: consecutive-stall tracking, ERR is sticky until reset.
   always_comb begin
      consec_d = '0;
      state_d  = state_q;
      if (nop_flag) begin
         consec_d = (consec_q == CONS_W'(STALL_LIMIT)) ? consec_q : consec_q + CONS_W'(1);
      end
      case (state_q)
         ST_RUN: begin
            if (nop_flag) begin
               state_d = (consec_d >= CONS_W'(STALL_LIMIT)) ? ST_ERR : ST_STALL;
            end
         end
         ST_STALL: begin
            if (!nop_flag) begin
               state_d = ST_RUN;
            end else if (consec_d >= CONS_W'(STALL_LIMIT)) begin
               state_d = ST_ERR;
            end
         end
         ST_ERR:  state_d = ST_ERR;
         default: state_d = ST_RUN;
      endcase
      err_d = (state_d == ST_ERR);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q         <= RESET_PC;
         ifid_instr_q <= NOP_INSTR;
         ifid_pc4_q   <= '0;
         ifid_valid_q <= 1'b0;
         idex_ctrl_q  <= '0;
         idex_valid_q <= 1'b0;
         consec_q     <= '0;
         state_q      <= ST_RUN;
         err_q        <= 1'b0;
      end else begin
         pc_q         <= pc_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_pc4_q   <= ifid_pc4_d;
         ifid_valid_q <= ifid_valid_d;
         idex_ctrl_q  <= idex_ctrl_d;
         idex_valid_q <= idex_valid_d;
         consec_q     <= consec_d;
         state_q      <= state_d;
         err_q        <= err_d;
      end
   end

   sat_counter #(.WIDTH(CNT_W), .ENABLE(1'b1)) u_stall_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .inc_en (nop_flag),
      .cnt    (stall_cnt)
   );

   sat_counter #(.WIDTH(CNT_W), .ENABLE(1'b1)) u_flush_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .inc_en (flush_take_c),
      .cnt    (flush_cnt)
   );

   assign pc          = pc_q;
   assign IF_ID_instr = ifid_instr_q;
   assign IF_ID_pc4   = ifid_pc4_q;
   assign IF_ID_valid = ifid_valid_q;
   assign ID_EX_ctrl  = idex_ctrl_q;
   assign ID_EX_valid = idex_valid_q;
   assign stall_err   = err_q;

endmodule

// File: tb/tb_fetch_decode_pipe.sv
// Directed bench for fetch_decode_pipe with hand-computed expectations (CNT_W=4).
module tb_fetch_decode_pipe;

   localparam int unsigned CTRL_W = 10;
   localparam int unsigned CNT_W  = 4;
   localparam logic [CTRL_W-1:0] CTRL_VAL = 10'h155;

   logic              clk;
   logic              rst_n;
   logic              PC_wr_en;
   logic              IF_ID_wr_en;
   logic              nop_flag;
   logic              flush_flag;
   logic [31:0]       pc_next;
   logic [31:0]       if_instr;
   logic [CTRL_W-1:0] id_ctrl;
   logic [31:0]       pc;
   logic [31:0]       IF_ID_instr;
   logic [31:0]       IF_ID_pc4;
   logic              IF_ID_valid;
   logic [CTRL_W-1:0] ID_EX_ctrl;
   logic              ID_EX_valid;
   logic [CNT_W-1:0]  stall_cnt;
   logic [CNT_W-1:0]  flush_cnt;
   logic              stall_err;

   int unsigned n_checks = 0;
   int unsigned n_errs   = 0;

   fetch_decode_pipe #(
      .RESET_PC    (32'h0000_0000),
      .CTRL_W      (CTRL_W),
      .CNT_W       (CNT_W),
      .STALL_LIMIT (4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .PC_wr_en    (PC_wr_en),
      .IF_ID_wr_en (IF_ID_wr_en),
      .nop_flag    (nop_flag),
      .flush_flag  (flush_flag),
      .pc_next     (pc_next),
      .if_instr    (if_instr),
      .id_ctrl     (id_ctrl),
      .pc          (pc),
      .IF_ID_instr (IF_ID_instr),
      .IF_ID_pc4   (IF_ID_pc4),
      .IF_ID_valid (IF_ID_valid),
      .ID_EX_ctrl  (ID_EX_ctrl),
      .ID_EX_valid (ID_EX_valid),
      .stall_cnt   (stall_cnt),
      .flush_cnt   (flush_cnt),
      .stall_err   (stall_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one rising edge, then settle on the falling edge for sampling/driving.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic pcw, input logic ifw, input logic nop, input logic fl,
                        input logic [31:0] nxt, input logic [31:0] ins);
      PC_wr_en    = pcw;
      IF_ID_wr_en = ifw;
      nop_flag    = nop;
      flush_flag  = fl;
      pc_next     = nxt;
      if_instr    = ins;
   endtask

   initial begin
      rst_n   = 1'b0;
      id_ctrl = CTRL_VAL;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      #12;
      check("rst_pc",        pc,                     32'h0);
      check("rst_ifid_inst", IF_ID_instr,            32'h0);
      check("rst_ifid_val",  32'(IF_ID_valid),       32'h0);
      check("rst_idex_val",  32'(ID_EX_valid),       32'h0);
      check("rst_stall_cnt", 32'(stall_cnt),         32'h0);
      check("rst_err",       32'(stall_err),         32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Sequential fetch 0 -> 4 -> 8 -> 12
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h4, 32'hA000_0000);
      step();
      check("seq1_pc",       pc,                     32'h4);
      check("seq1_inst",     IF_ID_instr,            32'hA000_0000);
      check("seq1_pc4",      IF_ID_pc4,              32'h4);
      check("seq1_ifid_val", 32'(IF_ID_valid),       32'h1);
      check("seq1_idex_val", 32'(ID_EX_valid),       32'h0);
      check("seq1_ctrl",     32'(ID_EX_ctrl),        32'(CTRL_VAL));
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h8, 32'hA000_0004);
      step();
      check("seq2_pc",       pc,                     32'h8);
      check("seq2_pc4",      IF_ID_pc4,              32'h8);
      check("seq2_idex_val", 32'(ID_EX_valid),       32'h1);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'hC, 32'hA000_0008);
      step();
      check("seq3_pc",       pc,                     32'hC);
      check("seq3_inst",     IF_ID_instr,            32'hA000_0008);

      // Load-use stall: hold PC and IF/ID, bubble ID/EX
      drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 32'hA000_000C);
      step();
      check("stall_pc",       pc,                    32'hC);
      check("stall_inst",     IF_ID_instr,           32'hA000_0008);
      check("stall_pc4",      IF_ID_pc4,             32'hC);
      check("stall_ifid_val", 32'(IF_ID_valid),      32'h1);
      check("stall_ctrl",     32'(ID_EX_ctrl),       32'h0);
      check("stall_idex_val", 32'(ID_EX_valid),      32'h0);
      check("stall_cnt1",     32'(stall_cnt),        32'h1);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'hA000_000C);
      step();
      check("resume_pc",      pc,                    32'h10);
      check("resume_ctrl",    32'(ID_EX_ctrl),       32'(CTRL_VAL));
      check("resume_err",     32'(stall_err),        32'h0);

      // Taken branch to 0x40
      drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h40, 32'hA000_0010);
      step();
      check("br_pc",          pc,                    32'h40);
      check("br_inst",        IF_ID_instr,           32'h0);
      check("br_pc4",         IF_ID_pc4,             32'h0);
      check("br_ifid_val",    32'(IF_ID_valid),      32'h0);
      check("br_idex_val",    32'(ID_EX_valid),      32'h1);
      check("br_flush_cnt",   32'(flush_cnt),        32'h1);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h44, 32'hA000_0040);
      step();
      check("tgt_pc",         pc,                    32'h44);
      check("tgt_inst",       IF_ID_instr,           32'hA000_0040);
      check("tgt_pc4",        IF_ID_pc4,             32'h44);
      check("tgt_idex_val",   32'(ID_EX_valid),      32'h0);

      // Stale flush during stall is ignored
      drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h48, 32'hA000_0044);
      step();
      check("sflush_inst",    IF_ID_instr,           32'hA000_0040);
      check("sflush_val",     32'(IF_ID_valid),      32'h1);
      check("sflush_cnt",     32'(flush_cnt),        32'h1);
      check("sflush_pc",      pc,                    32'h44);

      // Simultaneous bubble and flush
      drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h48, 32'hA000_0044);
      step();
      check("both_ifid_val",  32'(IF_ID_valid),      32'h0);
      check("both_inst",      IF_ID_instr,           32'h0);
      check("both_idex_val",  32'(ID_EX_valid),      32'h0);
      check("both_ctrl",      32'(ID_EX_ctrl),       32'h0);
      check("both_flush_cnt", 32'(flush_cnt),        32'h2);
      check("both_stall_cnt", 32'(stall_cnt),        32'h2);
      check("both_pc",        pc,                    32'h48);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h4C, 32'hA000_0048);
      step();
      check("gap_err",        32'(stall_err),        32'h0);

      // Four consecutive stalls raise the sticky error on the 4th edge
      drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h50, 32'hA000_004C);
      for (int i = 1; i <= 3; i++) begin
         step();
         check("long_err_pre", 32'(stall_err), 32'h0);
      end
      step();
      check("long_err_set",   32'(stall_err),        32'h1);
      check("long_stall_cnt", 32'(stall_cnt),        32'h6);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h50, 32'hA000_004C);
      step();
      step();
      check("err_sticky",     32'(stall_err),        32'h1);

      // Saturation at 15 with a 4-bit counter
      drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h54, 32'hA000_0050);
      for (int i = 0; i < 20; i++) begin
         step();
      end
      check("sat_cnt",        32'(stall_cnt),        32'hF);
      check("sat_err",        32'(stall_err),        32'h1);

      // Asynchronous reset mid-stall, away from any clock edge
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_pc",        pc,                    32'h0);
      check("arst_stall_cnt", 32'(stall_cnt),        32'h0);
      check("arst_flush_cnt", 32'(flush_cnt),        32'h0);
      check("arst_err",       32'(stall_err),        32'h0);
      check("arst_ifid_val",  32'(IF_ID_valid),      32'h0);
      check("arst_idex_val",  32'(ID_EX_valid),      32'h0);
      check("arst_ifid_pc4",  IF_ID_pc4,             32'h0);
      @(negedge clk);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h4, 32'hB000_0000);
      rst_n = 1'b1;
      step();
      check("post_pc",        pc,                    32'h4);
      check("post_inst",      IF_ID_instr,           32'hB000_0000);
      check("post_pc4",       IF_ID_pc4,             32'h4);
      check("post_err",       32'(stall_err),        32'h0);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
